sighash_sequencer: RTL
======================

# sighash_sequencer

Sequential controller that computes the BIP143 single-input sighash by time-multiplexing one shared SHA-256 compression core across the 11 compression steps of the flow. The steps are outputs hash (3), preimage hash (7) and final hash (1). It sits between the transaction-capture logic and the compression core, replacing a fully unrolled chain of 11 core instances. It latches the transaction, drives the core's data and chaining inputs step by step, captures each result and presents the final digest with a done pulse.

## Interface
Parameters:
- CORE_TIMEOUT, 255: maximum cycles to wait for `core_done` after a `core_start`; exceeding it aborts the job.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- transaction  in  3361  packed transaction, sampled on the accepted-start edge. Fields:
  - nversion [3359:3328], hash_prevouts [3327:3072], hash_sequence [3071:2816], in_txid [2815:2560], in_vout [2559:2528]
  - script [2527:656], in_amount [655:592], in_nseq [591:560], locktime [559:528], sighash_type [527:496]
  - bit 3360 unused
- busy  out  1  high whenever not in IDLE.
- valid  out  1  one-cycle pulse when `sighash` is updated.
- error  out  1  one-cycle pulse on core timeout.
- sighash  out  256  last completed digest; held until the next completion.
- core_start  out  1  one-cycle pulse launching a compression.
- core_data  out  512  message block; held stable from `core_start` until `core_done`.
- core_state  out  256  chaining input; held stable with `core_data`.
- core_next_state  in  256  core result; valid when `core_done` is high.
- core_done  in  1  core completion; honoured only in WAIT, ignored otherwise.

## Operation
- Derived values:
  - H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19.
  - enc = {t[127:64], t[495:312], t[63:0], t[311:128]} (496 bits).
  - P = {nversion, hash_prevouts, hash_sequence, in_txid, in_vout, script, in_amount, in_nseq, hout, locktime, sighash_type} (3120 bits).
  - FIN256 = 256'h8000…0100.
- FSM states:
  - IDLE: on start=1, latch transaction, clear step counter, go to ISSUE.
  - ISSUE: pulse `core_start`, go to WAIT.
  - WAIT: on `core_done`, capture `core_next_state` into chaining register `s`, or into `hout` at step 2, or into `sighash` at step 10. At step 10 go to DONE; otherwise step++ and go to ISSUE.
  - DONE: pulse `valid`, go to IDLE.
- Step schedule (data / state):
  - 0: {enc, 16'h8000} / H0.
  - 1: 512'h1f0 / s.
  - 2: {s, FIN256} / H0, result goes to hout.
  - 3: P[3119:2608] / H0.
  - 4–8: successive 512-bit slices P[2607:2096] … P[559:48] / s.
  - 9: {P[47:0], 464'h80…0c30} / s.
  - 10: {s, FIN256} / H0, result goes to sighash.
- Start behaviour: `start` outside IDLE is ignored, including in DONE. The latched transaction is unaffected by input changes mid-job.
- Timeout: a wait counter clears on ISSUE. If it reaches CORE_TIMEOUT in WAIT without `core_done`, pulse `error` and go to IDLE. `sighash` stays unchanged and `valid` does not assert.
- Reset values, all outputs 0: sighash=0, valid=0, error=0, busy=0, core_start=0, core_data=0, core_state=0. State returns to IDLE.
- Reset mid-job: the job is discarded; no `valid` or `error` pulse.

## Timing
- Accepted `start` is at cycle 0. The first `core_start` is at cycle 1.
- Core latency k ≥ 1: `core_done` arrives k cycles after `core_start`. The next `core_start` follows one cycle after `core_done`.
- `valid` rises at cycle 11k+12; `busy` is high from cycles 1 to 11k+12 inclusive. For k=1, valid is at cycle 23.
- `core_done` in the same cycle as `core_start` is ignored.
- A new `start` is accepted in the first IDLE cycle after DONE or after a timeout abort.

## Test plan
- Ideal core (k=1), arbitrary transaction, start pulse -> `valid` at cycle 23. `sighash` equals the software BIP143 double-SHA256 of P; exactly 11 `core_start` pulses are observed.
- Core with k=3 -> `valid` at cycle 45 with an identical digest; `core_data` and `core_state` stay constant while each step waits.
- Step probes -> step 0 drives core_state=H0 and core_data[15:0]=16'h8000; step 1 drives core_data=512'h1f0; step 9 drives core_data[11:0]=12'hc30.
- CORE_TIMEOUT=4 with `core_done` stuck at 0 -> `error` pulses at cycle 1+4+1; `busy` then drops, `valid` never asserts and `sighash` keeps its old value.
- Start at cycles 5 and 23 during a k=1 job, plus spurious `core_done` in ISSUE -> a single job runs with an unchanged digest; the extra starts are ignored.
- rst_n low at cycle 10 of a job -> all outputs 0 on the next edge. A fresh start then completes normally in 23 cycles.

Source files
------------

// File: rtl/sighash_sequencer_if.sv
// Handshake between the sighash sequencer and the shared SHA-256 compression core.
// The sequencer (master) launches one block; the core (slave) returns the chained state.
interface sighash_sequencer_if;
  logic         core_start;
  logic [511:0] core_data;
  logic [255:0] core_state;
  logic [255:0] core_next_state;
  logic         core_done;

  modport master (
    output core_start,
    output core_data,
    output core_state,
    input  core_next_state,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  core_data,
    input  core_state,
    output core_next_state,
    output core_done
  );
endinterface

// File: rtl/sighash_sequencer.sv
// BIP143 single-input sighash: runs the 11 compression steps (outputs hash, preimage
// hash, final hash) through one shared SHA-256 core, one step at a time.
module sighash_sequencer #(
  parameter int CORE_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3360:0]       transaction,
  output logic                busy,
  output logic                valid,
  output logic                error,
  output logic [255:0]        sighash,
  sighash_sequencer_if.master core
);

  localparam logic [255:0] H0 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  // Padding block for hashing a single 256-bit digest (length field = 256).
  localparam logic [255:0] FIN256  = {8'h80, 236'd0, 12'h100};
  // Padding tail for the 3120-bit preimage (length field = 0xc30).
  localparam logic [463:0] TAIL464 = {8'h80, 444'd0, 12'hc30};
  localparam int WCNT_W = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(CORE_TIMEOUT - 1);
  localparam logic [3:0] HOUT_STEP = 4'd2;
  localparam logic [3:0] LAST_STEP = 4'd10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  logic [3:0]          step;
  logic [3:0]          step_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [3359:0]       tx_q;
  logic [255:0]        s;
  logic [255:0]        hout;
  logic [255:0]        s_nxt;
  logic [255:0]        hout_nxt;
  logic                tx_unused;

  assign tx_unused = transaction[3360];

  function automatic logic [511:0] block_for(input logic [3:0]    stp,
                                             input logic [3359:0] tx,
                                             input logic [255:0]  s_v,
                                             input logic [255:0]  hout_v);
    logic [495:0]  enc;
    logic [3119:0] p;
    enc = {tx[127:64], tx[495:312], tx[63:0], tx[311:128]};
    p   = {tx[3359:560], hout_v, tx[559:496]};
    case (stp)
      4'd0:        return {enc, 16'h8000};
      4'd1:        return 512'h1f0;
      4'd2, 4'd10: return {s_v, FIN256};
      4'd3:        return p[3119:2608];
      4'd4:        return p[2607:2096];
      4'd5:        return p[2095:1584];
      4'd6:        return p[1583:1072];
      4'd7:        return p[1071:560];
      4'd8:        return p[559:48];
      4'd9:        return {p[47:0], TAIL464};
      default:     return '0;
    endcase
  endfunction

  // Steps that begin a fresh hash start from H0; the rest continue the chain.
  function automatic logic [255:0] chain_for(input logic [3:0] stp, input logic [255:0] s_v);
    case (stp)
      4'd0, 4'd2, 4'd3, 4'd10: return H0;
      default:                 return s_v;
    endcase
  endfunction

  // Values the chaining registers take once the current step's result is captured.
  always_comb begin
    step_nxt = step + 4'd1;
    s_nxt    = s;
    hout_nxt = hout;
    if (step == HOUT_STEP) hout_nxt = core.core_next_state;
    else                   s_nxt    = core.core_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      step            <= '0;
      wcnt            <= '0;
      busy            <= 1'b0;
      valid           <= 1'b0;
      error           <= 1'b0;
      sighash         <= '0;
      core.core_start <= 1'b0;
      core.core_data  <= '0;
      core.core_state <= '0;
    end else begin
      valid           <= 1'b0;
      error           <= 1'b0;
      core.core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_q            <= transaction[3359:0];
            step            <= '0;
            core.core_data  <= block_for(4'd0, transaction[3359:0], '0, '0);
            core.core_state <= H0;
            core.core_start <= 1'b1;
            busy            <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (core.core_done) begin
            if (step == LAST_STEP) begin
              sighash <= core.core_next_state;
              valid   <= 1'b1;
              state   <= DONE;
            end else begin
              s               <= s_nxt;
              hout            <= hout_nxt;
              step            <= step_nxt;
              core.core_data  <= block_for(step_nxt, tx_q, s_nxt, hout_nxt);
              core.core_state <= chain_for(step_nxt, s_nxt);
              core.core_start <= 1'b1;
              state           <= ISSUE;
            end
          end else if (wcnt == TMO_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
